// File: rtl/ift_response_checker.sv
// Response checker for IFT cell benches: walks the expected-response memory,
// compares DUT value/taint on each settled-sample strobe and reports pass/fail.
module ift_response_checker #(
  parameter int DATA_W  = 2,
  parameter int TAINT_W = 32,
  parameter int IDX_W   = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W:0]     vec_count,
  input  logic               tmode,
  output logic [IDX_W-1:0]   exp_addr,
  input  logic [DATA_W-1:0]  exp_y,
  input  logic [TAINT_W-1:0] exp_y_t,
  input  logic               sample,
  input  logic [DATA_W-1:0]  dut_y,
  input  logic [TAINT_W-1:0] dut_y_t,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_count,
  output logic [IDX_W-1:0]   first_err_idx,
  output logic               first_err_valid,
  output logic               overrun
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ARMED, DONE} state_t;

  localparam logic [IDX_W:0]   MAX_COUNT = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0]   COUNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t             state;
  logic [IDX_W:0]     count_q;
  logic               tmode_q;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  cmp_y;
  logic [TAINT_W-1:0] cmp_t;

  logic [IDX_W:0]     clamped_count;
  logic               value_mis;
  logic               taint_mis;
  logic               vec_fail;
  logic               last_vec;

  // Soundness mode only flags expected taint bits the DUT failed to report.
  always_comb begin
    clamped_count = (vec_count > MAX_COUNT) ? MAX_COUNT : vec_count;
    value_mis     = (dut_y != cmp_y);
    taint_mis     = tmode_q ? ((cmp_t & ~dut_y_t) != '0) : (dut_y_t != cmp_t);
    vec_fail      = value_mis | taint_mis;
    last_vec      = ({1'b0, idx} == (count_q - COUNT_ONE));
  end

  assign pass = done && (err_count == '0) && !overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      count_q         <= '0;
      tmode_q         <= 1'b0;
      idx             <= '0;
      cmp_y           <= '0;
      cmp_t           <= '0;
      exp_addr        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            count_q         <= clamped_count;
            tmode_q         <= tmode;
            idx             <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            overrun         <= 1'b0;
            if (clamped_count == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= FETCH;
              exp_addr <= '0;
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end else if (state == DONE && sample) begin
            overrun <= 1'b1;
          end
        end
        FETCH: begin
          state <= LOAD;
          if (sample) overrun <= 1'b1;
        end
        LOAD: begin
          cmp_y <= exp_y;
          cmp_t <= exp_y_t;
          state <= ARMED;
          if (sample) overrun <= 1'b1;
        end
        ARMED: begin
          if (sample) begin
            if (vec_fail) begin
              if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
              if (!first_err_valid) begin
                first_err_idx   <= idx;
                first_err_valid <= 1'b1;
              end
            end
            if (last_vec) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx      <= idx + IDX_ONE;
              exp_addr <= idx + IDX_ONE;
              state    <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ift_response_checker.sv
// Bench for ift_response_checker: table-driven runs with a per-sample scoreboard
// plus hand sequences for overrun, mid-run reset, empty run and count clamping.
module tb_ift_response_checker;

  localparam int DATA_W  = 2;
  localparam int TAINT_W = 32;
  localparam int IDX_W   = 6;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [IDX_W:0]     vec_count;
  logic               tmode;
  logic [IDX_W-1:0]   exp_addr;
  logic [DATA_W-1:0]  exp_y;
  logic [TAINT_W-1:0] exp_y_t;
  logic               sample;
  logic [DATA_W-1:0]  dut_y;
  logic [TAINT_W-1:0] dut_y_t;
  logic               busy;
  logic               done;
  logic               pass;
  logic [CNT_W-1:0]   err_count;
  logic [IDX_W-1:0]   first_err_idx;
  logic               first_err_valid;
  logic               overrun;

  ift_response_checker #(
    .DATA_W(DATA_W), .TAINT_W(TAINT_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .vec_count(vec_count), .tmode(tmode),
    .exp_addr(exp_addr), .exp_y(exp_y), .exp_y_t(exp_y_t), .sample(sample),
    .dut_y(dut_y), .dut_y_t(dut_y_t), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx),
    .first_err_valid(first_err_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Expected-response memory with one cycle of read latency.
  logic [DATA_W-1:0]  mem_y [64];
  logic [TAINT_W-1:0] mem_t [64];
  always @(posedge clk) begin
    exp_y   <= mem_y[exp_addr];
    exp_y_t <= mem_t[exp_addr];
  end

  typedef struct packed {
    logic [1:0]  ey;
    logic [31:0] et;
    logic [1:0]  dy;
    logic [31:0] dt;
  } vec_t;

  typedef struct {
    int first;
    int n;
    bit tm;
    int err;
    bit pass;
    bit fv;
    int fidx;
  } run_t;

  typedef struct {
    int err;
    bit fv;
    int fidx;
  } exp_t;

  vec_t vt [17];
  run_t runs [5];
  exp_t sb [$];

  int n_vec = 0;
  int n_fail = 0;
  int m_err;
  bit m_fv;
  int m_fidx;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_exp_addr"}, 32'(exp_addr), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_pass"}, 32'(pass), 0);
    checkOutput({tag, "_err_count"}, 32'(err_count), 0);
    checkOutput({tag, "_first_err_idx"}, 32'(first_err_idx), 0);
    checkOutput({tag, "_first_err_valid"}, 32'(first_err_valid), 0);
    checkOutput({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  task automatic loadMem(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      mem_y[i] = vt[first + i].ey;
      mem_t[i] = vt[first + i].et;
    end
  endtask

  // Returns at the negedge where the checker is armed for vector 0.
  task automatic doStart(input int n, input bit tm);
    @(negedge clk);
    start     = 1'b1;
    vec_count = (IDX_W+1)'(n);
    tmode     = tm;
    m_err     = 0;
    m_fv      = 1'b0;
    m_fidx    = 0;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      checkOutput("zero_done", 32'(done), 1);
      checkOutput("zero_pass", 32'(pass), 1);
      checkOutput("zero_busy", 32'(busy), 0);
    end else begin
      checkOutput("start_busy", 32'(busy), 1);
      checkOutput("start_exp_addr", 32'(exp_addr), 0);
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  // Drives one legal sample; the expected result is queued before the edge.
  task automatic applyStimulus(input vec_t v, input bit tm, input int idx,
                               input bit last, input bit wait_armed);
    bit   fail;
    exp_t e;
    fail = (v.dy != v.ey) || (tm ? ((v.et & ~v.dt) != 32'h0) : (v.dt != v.et));
    if (fail) begin
      m_err++;
      if (!m_fv) begin
        m_fv   = 1'b1;
        m_fidx = idx;
      end
    end
    e.err  = m_err;
    e.fv   = m_fv;
    e.fidx = m_fidx;
    sb.push_back(e);
    sample  = 1'b1;
    dut_y   = v.dy;
    dut_y_t = v.dt;
    @(negedge clk);
    sample = 1'b0;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      checkOutput("err_count", 32'(err_count), e.err);
      checkOutput("first_err_valid", 32'(first_err_valid), 32'(e.fv));
      if (e.fv) checkOutput("first_err_idx", 32'(first_err_idx), e.fidx);
    end
    checkOutput("done", 32'(done), 32'(last));
    checkOutput("busy", 32'(busy), 32'(!last));
    if (!last) begin
      checkOutput("fetch_exp_addr", 32'(exp_addr), idx + 1);
      if (wait_armed) begin
        @(negedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic checkRun(input run_t r);
    checkOutput("run_done", 32'(done), 1);
    checkOutput("run_pass", 32'(pass), 32'(r.pass));
    checkOutput("run_err_count", 32'(err_count), r.err);
    checkOutput("run_first_err_valid", 32'(first_err_valid), 32'(r.fv));
    if (r.fv) checkOutput("run_first_err_idx", 32'(first_err_idx), r.fidx);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;

    // {exp_y, exp_y_t, dut_y, dut_y_t}
    vt[0]  = '{2'd0, 32'h1,  2'd0, 32'h1};
    vt[1]  = '{2'd1, 32'h2,  2'd1, 32'h2};
    vt[2]  = '{2'd2, 32'h4,  2'd2, 32'h4};
    vt[3]  = '{2'd3, 32'h8,  2'd3, 32'h8};
    vt[4]  = '{2'd1, 32'h0,  2'd1, 32'h0};
    vt[5]  = '{2'd2, 32'h10, 2'd2, 32'h10};
    vt[6]  = '{2'd3, 32'h20, 2'd2, 32'h20};
    vt[7]  = '{2'd0, 32'h40, 2'd0, 32'h40};
    vt[8]  = '{2'd1, 32'h3,  2'd1, 32'h7};
    vt[9]  = '{2'd0, 32'h1,  2'd0, 32'h3};
    vt[10] = '{2'd1, 32'h5,  2'd1, 32'h4};
    vt[11] = '{2'd2, 32'h0,  2'd2, 32'hF};
    vt[12] = '{2'd3, 32'h0,  2'd1, 32'h0};
    vt[13] = '{2'd2, 32'h0,  2'd1, 32'h0};
    vt[14] = '{2'd0, 32'h1,  2'd0, 32'h1};
    vt[15] = '{2'd1, 32'h2,  2'd1, 32'h2};
    vt[16] = '{2'd2, 32'h4,  2'd2, 32'h4};

    // {first, n, tmode, err, pass, first_valid, first_idx}
    runs[0] = '{0, 4, 1'b0, 0, 1'b1, 1'b0, 0};
    runs[1] = '{4, 4, 1'b0, 1, 1'b0, 1'b1, 2};
    runs[2] = '{8, 1, 1'b1, 0, 1'b1, 1'b0, 0};
    runs[3] = '{8, 1, 1'b0, 1, 1'b0, 1'b1, 0};
    runs[4] = '{9, 4, 1'b1, 2, 1'b0, 1'b1, 1};

    for (int i = 0; i < 64; i++) begin
      mem_y[i] = '0;
      mem_t[i] = '0;
    end
    rst       = 1'b1;
    start     = 1'b0;
    sample    = 1'b0;
    vec_count = '0;
    tmode     = 1'b0;
    dut_y     = '0;
    dut_y_t   = '0;

    repeat (3) @(negedge clk);
    checkCleared("reset");
    rst = 1'b0;

    // A stray sample while idle must not register as an overrun.
    @(negedge clk);
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    checkOutput("idle_sample_overrun", 32'(overrun), 0);
    checkOutput("idle_sample_busy", 32'(busy), 0);

    for (int r = 0; r < 5; r++) begin
      loadMem(runs[r].first, runs[r].n);
      doStart(runs[r].n, runs[r].tm);
      for (int i = 0; i < runs[r].n; i++)
        applyStimulus(vt[runs[r].first + i], runs[r].tm, i, i == runs[r].n - 1, 1'b1);
      checkRun(runs[r]);
    end

    // Back-to-back samples: second lands in FETCH, vector 1 stays pending.
    loadMem(0, 2);
    doStart(2, 1'b0);
    applyStimulus(vt[0], 1'b0, 0, 1'b0, 1'b0);
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    checkOutput("overrun_set", 32'(overrun), 1);
    checkOutput("overrun_busy", 32'(busy), 1);
    checkOutput("overrun_err_count", 32'(err_count), 0);
    @(negedge clk);
    applyStimulus(vt[1], 1'b0, 1, 1'b1, 1'b1);
    checkOutput("overrun_pass", 32'(pass), 0);
    checkOutput("overrun_sticky", 32'(overrun), 1);

    // Reset while armed on vector 1, then a clean rerun.
    loadMem(13, 4);
    doStart(4, 1'b0);
    applyStimulus(vt[13], 1'b0, 0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkCleared("midrun_reset");
    loadMem(0, 4);
    doStart(4, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(vt[i], 1'b0, i, i == 3, 1'b1);
    checkRun(runs[0]);

    // Empty run: exp_addr keeps the last address of the previous run.
    checkOutput("zero_addr_before", 32'(exp_addr), 3);
    doStart(0, 1'b0);
    checkOutput("zero_addr_after", 32'(exp_addr), 3);
    @(negedge clk);
    checkOutput("zero_done_held", 32'(done), 1);

    // vec_count above 64 is clamped, so the run ends after 64 vectors.
    for (int i = 0; i < 64; i++) begin
      mem_y[i] = 2'(i);
      mem_t[i] = 32'(i);
    end
    doStart(100, 1'b0);
    for (int i = 0; i < 64; i++) begin
      v.ey = 2'(i);
      v.et = 32'(i);
      v.dy = 2'(i);
      v.dt = 32'(i);
      applyStimulus(v, 1'b0, i, i == 63, 1'b1);
    end
    checkOutput("clamp_pass", 32'(pass), 1);
    checkOutput("clamp_last_addr", 32'(exp_addr), 63);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
